// File: rtl/simon_sequencer.sv
// Simon game controller: LFSR note generation, sequence playback, press checking, round growth.
// Optional STRICT_TIMEOUT_EN: WAIT_IN loses after TIMEOUT_CYCLES with no press.
module simon_sequencer #(
  parameter int unsigned DEPTH          = 16,
  parameter int unsigned NOTE_CYCLES    = 12_500_000,
  parameter int unsigned GAP_CYCLES     = 5_000_000,
  parameter int unsigned TIMEOUT_CYCLES = 150_000_000,
  parameter logic [15:0] SEED           = 16'hACE1
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic                     START,
  input  logic [3:0]               BTN,
  output logic [1:0]               NOTE_SEL,
  output logic                     TONE_EN,
  output logic [$clog2(DEPTH):0]   SCORE,
  output logic                     PLAYING,
  output logic                     GAME_OVER,
  output logic                     WIN
);

  localparam int unsigned IdxW   = $clog2(DEPTH);
  localparam int unsigned LenW   = IdxW + 1;
  localparam int unsigned MaxNg  = (NOTE_CYCLES > GAP_CYCLES) ? NOTE_CYCLES : GAP_CYCLES;
  localparam int unsigned MaxCyc = (MaxNg > TIMEOUT_CYCLES) ? MaxNg : TIMEOUT_CYCLES;
  localparam int unsigned CntW   = $clog2(MaxCyc) + 1;
  localparam logic [CntW-1:0] NoteLoad = CntW'(NOTE_CYCLES - 1);
  localparam logic [CntW-1:0] GapLoad  = CntW'(GAP_CYCLES - 1);

  typedef enum logic [3:0] {
    StIdle, StAdd, StPlayTone, StPlayGap, StWaitIn, StInTone, StRoundGap, StWin, StLose
  } state_e;

  state_e          state_q, state_d;
  logic [LenW-1:0] len_q, len_d;
  logic [IdxW-1:0] idx_q, idx_d;
  logic [LenW-1:0] score_q, score_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [15:0]     lfsr_q, lfsr_d;
  logic [3:0]      btn_q, btn_prev_q;
  logic [1:0]      seq_q [DEPTH];
  logic            seq_we;

  logic [1:0]      note_sel_q, note_sel_d;
  logic            tone_en_q, tone_en_d;
  logic [LenW-1:0] score_out_q, score_out_d;
  logic            playing_q, playing_d;
  logic            game_over_q, game_over_d;
  logic            win_q, win_d;

  logic [3:0] press;
  logic       timer_done;
  logic       last_idx;

  // BTN is registered once before edge detection, giving the two-cycle press latency.
  assign press      = btn_q & ~btn_prev_q;
  assign timer_done = (cnt_q == '0);
  assign last_idx   = ({1'b0, idx_q} == (len_q - 1'b1));
  assign lfsr_d     = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? 16'hB400 : 16'h0000);

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    idx_d   = idx_q;
    score_d = score_q;
    cnt_d   = cnt_q;
    seq_we  = 1'b0;
    case (state_q)
      StIdle, StWin, StLose: begin
        if (START) begin
          state_d = StAdd;
          len_d   = '0;
          idx_d   = '0;
          score_d = '0;
        end
      end
      StAdd: begin
        seq_we  = 1'b1;
        len_d   = len_q + 1'b1;
        idx_d   = '0;
        cnt_d   = NoteLoad;
        state_d = StPlayTone;
      end
      StPlayTone: begin
        if (timer_done) begin
          cnt_d   = GapLoad;
          state_d = StPlayGap;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      StPlayGap: begin
        if (timer_done) begin
          if (last_idx) begin
            idx_d   = '0;
            state_d = StWaitIn;
`ifdef STRICT_TIMEOUT_EN
            cnt_d   = CntW'(TIMEOUT_CYCLES - 1);
`endif
          end else begin
            idx_d   = idx_q + 1'b1;
            cnt_d   = NoteLoad;
            state_d = StPlayTone;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      StWaitIn: begin
        if (press != 4'b0000) begin
          // Two or more simultaneous edges count as a wrong press.
          if ($onehot(press) && press[seq_q[idx_q]]) begin
            cnt_d   = NoteLoad;
            state_d = StInTone;
          end else begin
            state_d = StLose;
          end
        end
`ifdef STRICT_TIMEOUT_EN
        else if (timer_done) begin
          state_d = StLose;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
`endif
      end
      StInTone: begin
        if (timer_done) begin
          if (!last_idx) begin
            idx_d   = idx_q + 1'b1;
            state_d = StWaitIn;
`ifdef STRICT_TIMEOUT_EN
            cnt_d   = CntW'(TIMEOUT_CYCLES - 1);
`endif
          end else begin
            score_d = len_q;
            if (len_q == LenW'(DEPTH)) begin
              state_d = StWin;
            end else begin
              cnt_d   = GapLoad;
              state_d = StRoundGap;
            end
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      StRoundGap: begin
        if (timer_done) begin
          state_d = StAdd;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Outputs are a registered image of the current state, so they lag transitions by one cycle.
  always_comb begin
    note_sel_d  = note_sel_q;
    tone_en_d   = state_q inside {StPlayTone, StInTone};
    score_out_d = score_q;
    playing_d   = !(state_q inside {StIdle, StWin, StLose});
    game_over_d = state_q inside {StWin, StLose};
    win_d       = (state_q == StWin);
    if (tone_en_d) begin
      note_sel_d = seq_q[idx_q];
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q     <= StIdle;
      len_q       <= '0;
      idx_q       <= '0;
      score_q     <= '0;
      cnt_q       <= '0;
      lfsr_q      <= SEED;
      btn_q       <= '0;
      btn_prev_q  <= '0;
      note_sel_q  <= '0;
      tone_en_q   <= 1'b0;
      score_out_q <= '0;
      playing_q   <= 1'b0;
      game_over_q <= 1'b0;
      win_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      len_q       <= len_d;
      idx_q       <= idx_d;
      score_q     <= score_d;
      cnt_q       <= cnt_d;
      lfsr_q      <= lfsr_d;
      btn_q       <= BTN;
      btn_prev_q  <= btn_q;
      note_sel_q  <= note_sel_d;
      tone_en_q   <= tone_en_d;
      score_out_q <= score_out_d;
      playing_q   <= playing_d;
      game_over_q <= game_over_d;
      win_q       <= win_d;
    end
  end

  always_ff @(posedge CLK) begin
    if (seq_we) begin
      seq_q[len_q[IdxW-1:0]] <= lfsr_q[1:0];
    end
  end

  assign NOTE_SEL  = note_sel_q;
  assign TONE_EN   = tone_en_q;
  assign SCORE     = score_out_q;
  assign PLAYING   = playing_q;
  assign GAME_OVER = game_over_q;
  assign WIN       = win_q;

endmodule

// File: tb/tb_simon_sequencer.sv
// Randomized self-checking bench for simon_sequencer against an LFSR/queue game model.
module tb_simon_sequencer;

  localparam int unsigned DEPTH   = 4;
  localparam int unsigned NOTE    = 4;
  localparam int unsigned GAP     = 2;
  localparam int unsigned TMO     = 20;
  localparam logic [15:0] SEED    = 16'hACE1;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [3:0] btn;
  logic [1:0] note_sel;
  logic       tone_en;
  logic [2:0] score;
  logic       playing;
  logic       game_over;
  logic       win;

  simon_sequencer #(
    .DEPTH          (DEPTH),
    .NOTE_CYCLES    (NOTE),
    .GAP_CYCLES     (GAP),
    .TIMEOUT_CYCLES (TMO),
    .SEED           (SEED)
  ) dut (
    .CLK       (clk),
    .RST       (rst),
    .START     (start),
    .BTN       (btn),
    .NOTE_SEL  (note_sel),
    .TONE_EN   (tone_en),
    .SCORE     (score),
    .PLAYING   (playing),
    .GAME_OVER (game_over),
    .WIN       (win)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
  endtask

  // Reference: the random value available in each cycle, indexed by cycle number.
  function automatic logic [15:0] lfsr_step(input logic [15:0] v);
    return v[0] ? ((v >> 1) ^ 16'hB400) : (v >> 1);
  endfunction

  logic [15:0] mdl_lfsr = 16'h0;
  int          cyc = 0;
  logic [15:0] hist [0:65535];

  always @(posedge clk) begin
    mdl_lfsr          <= rst ? SEED : lfsr_step(mdl_lfsr);
    hist[16'(cyc + 1)] <= rst ? SEED : lfsr_step(mdl_lfsr);
    cyc               <= cyc + 1;
  end

  int exp_seq[$];

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_tone(input string tag, input logic lvl, input int budget);
    int n = 0;
    while (tone_en !== lvl && n < budget) begin
      @(negedge clk);
      n++;
    end
    check(tag, int'(tone_en), int'(lvl));
  endtask

  task automatic new_game();
    btn = 4'b0;
    tick($urandom_range(0, 7));
    start = 1'b1;
    tick(1);
    start = 1'b0;
    exp_seq.delete();
  endtask

  // Watches playback of round r; the new note was drawn in ADD, two cycles before the first tone.
  task automatic playback(input int r, input bit noisy);
    int hi;
    wait_tone("round_start", 1'b1, 200);
    exp_seq.push_back(int'(hist[16'(cyc - 2)][1:0]));
    check("score_before_round", int'(score), r - 1);
    check("playing", int'(playing), 1);
    for (int i = 0; i < r; i++) begin
      if (i > 0) wait_tone("play_on", 1'b1, 50);
      check("play_note", int'(note_sel), exp_seq[i]);
      hi = 0;
      while (tone_en === 1'b1 && hi < 20) begin
        btn = (noisy && hi == 0) ? 4'($urandom_range(1, 15)) : 4'b0;
        @(negedge clk);
        hi++;
      end
      btn = 4'b0;
      check("play_len", hi, NOTE);
    end
    tick(3);
    if (noisy) check("noise_ignored", int'(game_over), 0);
  endtask

  task automatic press(input int note, input bit hold);
    tick($urandom_range(0, 3));
    btn = 4'b0001 << note;
    wait_tone("fb_on", 1'b1, 10);
    check("fb_note", int'(note_sel), note);
    if (!hold) btn = 4'b0;
    wait_tone("fb_off", 1'b0, 10);
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_tone"}, int'(tone_en), 0);
    check({tag, "_note"}, int'(note_sel), 0);
    check({tag, "_score"}, int'(score), 0);
    check({tag, "_playing"}, int'(playing), 0);
    check({tag, "_over"}, int'(game_over), 0);
    check({tag, "_win"}, int'(win), 0);
  endtask

  initial begin
    #10_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int wrong;
    int saw;
    rst   = 1'b1;
    start = 1'b0;
    btn   = 4'b0;
    tick(3);
    check_idle_outputs("reset");
    rst = 1'b0;
    tick(2);

    // Perfect game with noisy playback in round 2.
    new_game();
    for (int r = 1; r <= int'(DEPTH); r++) begin
      playback(r, r == 2);
      for (int i = 0; i < r; i++) press(exp_seq[i], 1'b0);
    end
    tick(2);
    check("win_win", int'(win), 1);
    check("win_over", int'(game_over), 1);
    check("win_tone", int'(tone_en), 0);
    check("win_playing", int'(playing), 0);
    check("win_score", int'(score), DEPTH);

    // Wrong button on the second press of round 2.
    new_game();
    playback(1, 1'b0);
    press(exp_seq[0], 1'b0);
    playback(2, 1'b0);
    press(exp_seq[0], 1'b0);
    wrong = (exp_seq[1] + 1 + int'($urandom_range(0, 2))) % 4;
    btn = 4'b0001 << wrong;
    tick(4);
    btn = 4'b0;
    check("lose_over", int'(game_over), 1);
    check("lose_win", int'(win), 0);
    check("lose_score", int'(score), 1);
    check("lose_playing", int'(playing), 0);
    check("lose_tone", int'(tone_en), 0);

    // Restart from LOSE, then two buttons rising together.
    start = 1'b1;
    tick(1);
    start = 1'b0;
    exp_seq.delete();
    tick(2);
    check("restart_score", int'(score), 0);
    check("restart_playing", int'(playing), 1);
    check("restart_over", int'(game_over), 0);
    playback(1, 1'b0);
    btn = 4'b0011;
    tick(4);
    btn = 4'b0;
    check("dual_over", int'(game_over), 1);
    check("dual_win", int'(win), 0);

    // Held button across IN_TONE into WAIT_IN yields one press only.
    new_game();
    playback(1, 1'b0);
    press(exp_seq[0], 1'b0);
    playback(2, 1'b0);
    press(exp_seq[0], 1'b1);
    saw = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (tone_en === 1'b1 || game_over === 1'b1) saw = 1;
    end
    check("held_no_press", saw, 0);
    btn = 4'b0;
    tick(1);
    press(exp_seq[1], 1'b0);

    // Reset in the middle of press feedback.
    playback(3, 1'b0);
    tick($urandom_range(0, 3));
    btn = 4'b0001 << exp_seq[0];
    wait_tone("rst_fb_on", 1'b1, 10);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    btn = 4'b0;
    check_idle_outputs("midrst");
    tick(5);
    check("midrst_stay_idle", int'(playing), 0);

    // Press timeout behaviour.
    new_game();
    playback(1, 1'b0);
`ifdef STRICT_TIMEOUT_EN
    tick(30);
    check("timeout_over", int'(game_over), 1);
    check("timeout_win", int'(win), 0);
`else
    tick(1000);
    check("no_timeout_playing", int'(playing), 1);
    check("no_timeout_over", int'(game_over), 0);
    press(exp_seq[0], 1'b0);
    playback(2, 1'b0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/simon_sequencer.md
# simon_sequencer

Game controller for the Simon top level. Generates the random note sequence and replays it through the tone oscillator by driving its note select and a tone enable. Checks the player's button presses against the stored sequence and grows the sequence one note per round until the player wins or errs. Sequence storage, LFSR, edge detection and all game timing are internal; the oscillator remains a pure datapath.

## Interface
Parameters:
- DEPTH, 16 — maximum sequence length (win threshold); power of two, 2..64
- NOTE_CYCLES, 12_500_000 — clocks a tone sounds (playback and press feedback)
- GAP_CYCLES, 5_000_000 — clocks of silence after each played note and between rounds
- TIMEOUT_CYCLES, 150_000_000 — clocks allowed per press (used only with STRICT_TIMEOUT_EN)
- SEED, 16'hACE1 — LFSR reset value; must be nonzero

Ports:
- CLK  in  1 — clock; all logic rising-edge
- RST  in  1 — synchronous, active-high reset
- START  in  1 — begin a new game; level, sampled in IDLE/WIN/LOSE
- BTN  in  4 — player buttons, already debounced, level; BTN[k] means note k
- NOTE_SEL  out  2 — note index to oscillator
- TONE_EN  out  1 — oscillator enable (gates AUDIO at top level)
- SCORE  out  clog2(DEPTH)+1 — rounds completed
- PLAYING  out  1 — high in every state except IDLE/WIN/LOSE
- GAME_OVER  out  1 — high in WIN and LOSE
- WIN  out  1 — high in WIN only

## Operation
- States: IDLE, ADD, PLAY_TONE, PLAY_GAP, WAIT_IN, IN_TONE, ROUND_GAP, WIN, LOSE.
- Reset (any state, mid-game included): state IDLE, length 0, index 0, SCORE 0, NOTE_SEL 0, TONE_EN 0, PLAYING/GAME_OVER/WIN 0, LFSR = SEED, BTN history = 0, sequence memory contents don't-care.
- LFSR: 16-bit Galois, mask 16'hB400, advances every non-reset cycle in every state.
- IDLE/WIN/LOSE, START=1 → ADD; length, index, SCORE cleared.
- ADD: seq[length] ← LFSR[1:0]; length++; index 0 → PLAY_TONE.
- PLAY_TONE: NOTE_SEL=seq[index], TONE_EN=1 for NOTE_CYCLES → PLAY_GAP.
- PLAY_GAP: TONE_EN=0 for GAP_CYCLES; if index==length-1 then index 0 → WAIT_IN, else index++ → PLAY_TONE.
- Press edge: BTN & ~BTN_prev (BTN_prev registered every cycle). Acted on only in WAIT_IN; edges in any other state are discarded.
- WAIT_IN, exactly one edge bit k set: if k==seq[index] → IN_TONE with NOTE_SEL=k; otherwise → LOSE.
- WAIT_IN, two or more edge bits in the same cycle → LOSE.
- IN_TONE: TONE_EN=1 for NOTE_CYCLES. Then:
  - index<length-1: index++ → WAIT_IN
  - else SCORE=length; length==DEPTH → WIN, otherwise → ROUND_GAP
- ROUND_GAP: TONE_EN=0 for GAP_CYCLES → ADD.
- WIN/LOSE: TONE_EN=0; hold until START or RST.
- Single down-counter shared by all timed states, loaded on state entry; one state per count, no overlap.

## Timing
- All outputs registered; visible the cycle after the state transition.
- START sampled cycle N → ADD at N+1 → PLAY_TONE at N+2 → TONE_EN high N+3 through N+2+NOTE_CYCLES.
- Press latency: BTN rises cycle N → edge evaluated at N+1 → IN_TONE (or LOSE) at N+2.
- Holding a button produces one press. Releasing during IN_TONE and re-pressing is discarded (not WAIT_IN).
- Round r (length r) lasts r·(NOTE_CYCLES+GAP_CYCLES) plus ~3 cycles of playback overhead before WAIT_IN.

## Configuration
- STRICT_TIMEOUT_EN defined: in WAIT_IN, the shared counter loads TIMEOUT_CYCLES on entry. Reaching 0 with no edge → LOSE. The counter reloads on each re-entry to WAIT_IN.
- Undefined: WAIT_IN waits indefinitely; the TIMEOUT_CYCLES parameter is unused.

## Test plan
Bench parameters: DEPTH=4, NOTE_CYCLES=4, GAP_CYCLES=2, TIMEOUT_CYCLES=20, SEED=16'hACE1.
- Reset then START pulse → PLAYING=1; TONE_EN high exactly 4 cycles with NOTE_SEL = model LFSR[1:0] captured in ADD; then WAIT_IN.
- Perfect game (bench mirrors seq from NOTE_SEL) → SCORE steps 1,2,3,4; then WIN=1, GAME_OVER=1, TONE_EN=0.
- Round 2, wrong button on second press → LOSE, SCORE=1, GAME_OVER=1, WIN=0; later START → SCORE=0, new game.
- BTN=4'b0011 rising together in WAIT_IN → LOSE. BTN held high across IN_TONE into WAIT_IN → no extra press registered.
- Presses during PLAY_TONE/PLAY_GAP → ignored, no state change. RST asserted mid-IN_TONE → next cycle IDLE, all outputs 0.
- With STRICT_TIMEOUT_EN: no press for 20 cycles in WAIT_IN → LOSE. Without it: 1000 idle cycles → still WAIT_IN.
